// File: rtl/main_control_fsm_pkg.sv
// Purpose: shared constants and types for the multicycle RV64-subset main controller.
//   Opcode/funct3 encodings, ALU_op encodings, state/class/trap-cause enums and
//   the instruction-class decode helper.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BEQ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_LD  = 2'd1,
    CLS_SD  = 2'd2,
    CLS_BEQ = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_e;

  typedef struct packed {
    logic legal;
    cls_e cls;
  } dec_t;

  // Classify an instruction word; R-type is accepted on opcode alone.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    d.legal = 1'b0;
    d.cls   = CLS_R;
    unique case (instr[6:0])
      OP_RTYPE: begin
        d.legal = 1'b1;
        d.cls   = CLS_R;
      end
      OP_LOAD: begin
        d.legal = (instr[14:12] == F3_LD);
        d.cls   = CLS_LD;
      end
      OP_STORE: begin
        d.legal = (instr[14:12] == F3_SD);
        d.cls   = CLS_SD;
      end
      OP_BRANCH: begin
        d.legal = (instr[14:12] == F3_BEQ);
        d.cls   = CLS_BEQ;
      end
      default: begin
        d.legal = 1'b0;
        d.cls   = CLS_R;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Purpose: memory handshake bundle between the controller and the imem/dmem side.
//   imem_req/imem_ack : instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack : data access handshake (we=1 store, 0 load)
// Modports: master = controller, slave = memory side.
interface main_control_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/main_control_fsm_ack_watchdog.sv
// Purpose: wait-cycle counter for the fetch/data handshakes.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_clear     : hold the count at zero (asserted outside the wait states)
//   i_enable    : a wait cycle without ack is in progress
//   o_expired   : this wait cycle is the LIMIT-th without ack (combinational)
// LIMIT = 0 disables expiry.
module ack_watchdog #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned TO_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned       LAST_I = (LIMIT == 0) ? 0 : LIMIT - 1;
  localparam logic [TO_W-1:0]   LAST   = TO_W'(LAST_I);

  logic [TO_W-1:0] r_cnt;
  logic            w_at_last;

  // The count holds the number of completed wait cycles, so the LIMIT-th
  // waiting cycle is the one that sees LIMIT-1.
  assign w_at_last = (LIMIT != 0) && (r_cnt == LAST);
  assign o_expired = i_enable && w_at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !w_at_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Purpose: multicycle main controller for the RV64 subset core
//   (add/sub/and/or, ld, sd, beq). Fetches over imem, decodes, sequences the
//   datapath, handles memory waits, illegal-instruction and ack-timeout traps,
//   and counts retired instructions.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   run               : level enable for leaving IDLE / continuing after retire
//   instr             : IR contents, valid from DECODE onward
//   mem               : imem/dmem handshake bundle (master side)
//   ir_write/pc_write : IR load and PC+4 strobes (FETCH with imem_ack)
//   pc_write_cond     : branch PC update (datapath ANDs with zero)
//   ctrl_ALU_op       : 00 ld/sd, 01 beq, 10 R-type
//   alu_src, mem_to_reg, reg_write : datapath selects/strobes
//   busy, trap, trap_cause, retired : status
module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [31:0]         instr,
  main_control_fsm_if.master  mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          ctrl_ALU_op,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                busy,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    retired
);

  state_e           r_state;
  cls_e             r_cls;
  cause_e           r_cause;
  logic [CNT_W-1:0] r_retired;

  state_e w_next;
  cause_e w_next_cause;
  logic   w_retire;
  logic   w_expired;
  logic   w_wd_clear;
  logic   w_wd_enable;
  dec_t   w_dec;

  assign w_dec = decode_instr(instr);

  assign w_wd_clear  = (r_state != ST_FETCH) && (r_state != ST_MEM);
  assign w_wd_enable = ((r_state == ST_FETCH) && !mem.imem_ack) ||
                       ((r_state == ST_MEM)   && !mem.dmem_ack);

  ack_watchdog #(
    .LIMIT (ACK_TIMEOUT),
    .TO_W  (TO_W)
  ) u_ack_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next       = r_state;
    w_next_cause = r_cause;
    w_retire     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        // An ack on the limit cycle takes priority over the timeout.
        if (mem.imem_ack) begin
          w_next = ST_DECODE;
        end else if (w_expired) begin
          w_next       = ST_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (w_dec.legal) begin
          w_next = ST_EXEC;
        end else begin
          w_next       = ST_TRAP;
          w_next_cause = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        unique case (r_cls)
          CLS_R:          w_next = ST_WB;
          CLS_LD, CLS_SD: w_next = ST_MEM;
          CLS_BEQ: begin
            w_retire = 1'b1;
            w_next   = run ? ST_FETCH : ST_IDLE;
          end
          default:        w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          if (r_cls == CLS_SD) begin
            w_retire = 1'b1;
            w_next   = run ? ST_FETCH : ST_IDLE;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_next       = ST_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        w_retire = 1'b1;
        w_next   = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        w_next = ST_TRAP;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cls     <= CLS_R;
      r_cause   <= CAUSE_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_next_cause;
      if ((r_state == ST_DECODE) && w_dec.legal) begin
        r_cls <= w_dec.cls;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // Moore output decode, except the fetch strobes which follow imem_ack.
  always_comb begin
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.dmem_we   = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ctrl_ALU_op   = ALUOP_MEM;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        mem.imem_req = 1'b1;
        ir_write     = mem.imem_ack;
        pc_write     = mem.imem_ack;
      end
      ST_EXEC: begin
        unique case (r_cls)
          CLS_R:   ctrl_ALU_op = ALUOP_R;
          CLS_BEQ: begin
            ctrl_ALU_op   = ALUOP_BEQ;
            pc_write_cond = 1'b1;
          end
          default: begin
            ctrl_ALU_op = ALUOP_MEM;
            alu_src     = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (r_cls == CLS_SD);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_cls == CLS_LD);
      end
      default: begin
      end
    endcase
  end

  assign busy       = (r_state != ST_IDLE) && (r_state != ST_TRAP);
  assign trap       = (r_state == ST_TRAP);
  assign trap_cause = r_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_LD  = 32'h00813083;
  localparam logic [31:0] I_SD  = 32'h00113423;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] instr;
  logic        ir_write, pc_write, pc_write_cond;
  logic [1:0]  ctrl_ALU_op;
  logic        alu_src, mem_to_reg, reg_write, busy, trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  int n_assert = 0;
  int n_fail   = 0;

  main_control_fsm_if bus ();

  main_control_fsm #(
    .CNT_W       (32),
    .ACK_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .instr         (instr),
    .mem           (bus),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ctrl_ALU_op   (ctrl_ALU_op),
    .alu_src       (alu_src),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .busy          (busy),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    run          = 1'b0;
    instr        = 32'h0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #3;
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_retired", retired, 0);
    chk("rst_aluop", ctrl_ALU_op, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_hold", busy, 0);

    // 1: add, imem_ack one cycle late
    run = 1'b1;
    step();                                   // FETCH
    chk("t1_fetch_req", bus.imem_req, 1);
    chk("t1_fetch_busy", busy, 1);
    chk("t1_irw_noack", ir_write, 0);
    step();                                   // FETCH (waiting)
    chk("t1_fetch_wait", bus.imem_req, 1);
    bus.imem_ack = 1'b1; instr = I_ADD;
    #1;
    chk("t1_ir_write", ir_write, 1);
    chk("t1_pc_write", pc_write, 1);
    step(); bus.imem_ack = 1'b0;              // DECODE
    chk("t1_dec_req", bus.imem_req, 0);
    chk("t1_dec_busy", busy, 1);
    step();                                   // EXEC
    chk("t1_exec_aluop", ctrl_ALU_op, 2'b10);
    chk("t1_exec_alusrc", alu_src, 0);
    chk("t1_exec_rw", reg_write, 0);
    step();                                   // WB
    chk("t1_wb_rw", reg_write, 1);
    chk("t1_wb_m2r", mem_to_reg, 0);
    chk("t1_wb_ret", retired, 0);
    step();                                   // FETCH
    chk("t1_retired", retired, 1);
    chk("t1_refetch", bus.imem_req, 1);

    // 2: ld, dmem_ack on 3rd MEM cycle
    bus.imem_ack = 1'b1; instr = I_LD;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // EXEC
    chk("t2_exec_aluop", ctrl_ALU_op, 2'b00);
    chk("t2_exec_alusrc", alu_src, 1);
    step();                                   // MEM1
    chk("t2_mem1_req", bus.dmem_req, 1);
    chk("t2_mem1_we", bus.dmem_we, 0);
    step();                                   // MEM2
    chk("t2_mem2_req", bus.dmem_req, 1);
    step();                                   // MEM3
    chk("t2_mem3_req", bus.dmem_req, 1);
    bus.dmem_ack = 1'b1;
    step(); bus.dmem_ack = 1'b0;              // WB
    chk("t2_wb_dreq", bus.dmem_req, 0);
    chk("t2_wb_rw", reg_write, 1);
    chk("t2_wb_m2r", mem_to_reg, 1);
    step();                                   // FETCH
    chk("t2_retired", retired, 2);

    // 3: sd then beq
    bus.imem_ack = 1'b1; instr = I_SD;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // EXEC
    chk("t3_sd_alusrc", alu_src, 1);
    step();                                   // MEM
    chk("t3_sd_req", bus.dmem_req, 1);
    chk("t3_sd_we", bus.dmem_we, 1);
    bus.dmem_ack = 1'b1;
    #1;
    chk("t3_sd_norw", reg_write, 0);
    step(); bus.dmem_ack = 1'b0;              // FETCH
    chk("t3_sd_retired", retired, 3);
    chk("t3_sd_fetch", bus.imem_req, 1);
    chk("t3_sd_norw2", reg_write, 0);
    bus.imem_ack = 1'b1; instr = I_BEQ;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // EXEC
    chk("t3_beq_pwc", pc_write_cond, 1);
    chk("t3_beq_aluop", ctrl_ALU_op, 2'b01);
    chk("t3_beq_alusrc", alu_src, 0);
    chk("t3_beq_ret_pre", retired, 3);
    step();                                   // FETCH
    chk("t3_beq_fetch", bus.imem_req, 1);
    chk("t3_beq_pwc_off", pc_write_cond, 0);
    chk("t3_retired", retired, 4);

    // 4: illegal instruction
    bus.imem_ack = 1'b1; instr = I_BAD;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // TRAP
    chk("t4_trap", trap, 1);
    chk("t4_cause", trap_cause, 2'b01);
    chk("t4_busy", busy, 0);
    chk("t4_ireq", bus.imem_req, 0);
    step(); step();
    chk("t4_ireq_hold", bus.imem_req, 0);
    chk("t4_trap_hold", trap, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_trap", trap, 0);
    chk("t4_rst_cause", trap_cause, 0);
    chk("t4_rst_retired", retired, 0);
    step();
    rst_n = 1'b1;

    // 5a: ld with no dmem_ack -> timeout after 4 MEM cycles
    step();                                   // FETCH
    bus.imem_ack = 1'b1; instr = I_LD;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // EXEC
    step(); step(); step(); step();           // MEM1..MEM4
    chk("t5_mem4_req", bus.dmem_req, 1);
    chk("t5_mem4_busy", busy, 1);
    step();                                   // TRAP
    chk("t5_trap", trap, 1);
    chk("t5_cause", trap_cause, 2'b10);
    chk("t5_dreq", bus.dmem_req, 0);
    chk("t5_busy", busy, 0);

    // 5b: ack on the 4th MEM cycle wins over the timeout
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    step();                                   // FETCH
    bus.imem_ack = 1'b1; instr = I_LD;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // EXEC
    step(); step(); step(); step();           // MEM1..MEM4
    bus.dmem_ack = 1'b1;
    step(); bus.dmem_ack = 1'b0;              // WB
    chk("t5b_wb_rw", reg_write, 1);
    chk("t5b_notrap", trap, 0);
    step();                                   // FETCH
    chk("t5b_retired", retired, 1);

    // 6a: run drops during EXEC of add
    bus.imem_ack = 1'b1; instr = I_ADD;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // EXEC
    run = 1'b0;
    step();                                   // WB
    chk("t6_wb_rw", reg_write, 1);
    chk("t6_wb_busy", busy, 1);
    step();                                   // IDLE
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_ireq", bus.imem_req, 0);
    chk("t6_retired", retired, 2);
    step();
    chk("t6_idle_hold", bus.imem_req, 0);

    // 6b: reset in the middle of MEM
    run = 1'b1;
    step();                                   // FETCH
    bus.imem_ack = 1'b1; instr = I_LD;
    step(); bus.imem_ack = 1'b0;              // DECODE
    step();                                   // EXEC
    step();                                   // MEM
    chk("t6b_mem_req", bus.dmem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("t6b_rst_dreq", bus.dmem_req, 0);
    chk("t6b_rst_busy", busy, 0);
    chk("t6b_rst_ret", retired, 0);
    run = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6b_idle", busy, 0);
    // ack outside FETCH is ignored
    bus.imem_ack = 1'b1;
    #1;
    chk("t6b_ign_irw", ir_write, 0);
    chk("t6b_ign_pcw", pc_write, 0);
    step();
    bus.imem_ack = 1'b0;
    chk("t6b_ign_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
